// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);
    localparam int unsigned STAT_W     = 16;

    typedef enum logic {
        ST_RR     = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_F = 1'b0,
        REQ_L = 1'b1
    } req_id_e;

    // One-stage response pipeline: owner, error and read-data routing per port
    typedef struct packed {
        logic f_vld;
        logic f_err;
        logic f_rd;
        logic l_vld;
        logic l_err;
        logic l_rd;
    } rsp_pipe_t;

endpackage

// File: rtl/imem_addr_check.sv
// Byte-address legality check (aligned and in range) and word index for the instruction memory.
module imem_addr_check
    import imem_pkg::*;
#(
    parameter  int unsigned AW    = 32,
    parameter  int unsigned DEPTH = 128,
    localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [AW-1:0] addr_i,
    output logic          legal_o,
    output logic [IW-1:0] idx_o
);

    logic [AW-1:0] word;

    // Any nonzero bit above the index range pushes the word number past DEPTH
    always_comb begin
        word    = addr_i >> WORD_SHIFT;
        legal_o = (addr_i[WORD_SHIFT-1:0] == '0) && (word < AW'(DEPTH));
        idx_o   = word[IW-1:0];
    end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing the single-port instruction memory between fetch (F) and loader (L).
// Optional IMEM_ARB_STATS_EN builds 16-bit saturating grant/conflict counters.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [AW-1:0]     f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [AW-1:0]     l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_err,
    output logic              locked,
    output logic              m_en,
    output logic              m_we,
    output logic [AW-1:0]     m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [STAT_W-1:0] stat_f_grants,
    output logic [STAT_W-1:0] stat_l_grants,
    output logic [STAT_W-1:0] stat_conflicts
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    arb_state_e state_q, state_d;
    req_id_e    last_q, last_d;
    rsp_pipe_t  rsp_q, rsp_d;
    logic       locked_q;

    logic [AW-1:0] chk_addr;
    logic          chk_legal;
    logic [IW-1:0] chk_idx;

    // Grant selection and lock FSM
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        f_gnt   = 1'b0;
        l_gnt   = 1'b0;
        case (state_q)
            ST_RR: begin
                if (f_req && l_req) begin
                    if (last_q == REQ_L) f_gnt = 1'b1;
                    else                 l_gnt = 1'b1;
                end else begin
                    f_gnt = f_req;
                    l_gnt = l_req;
                end
                if (l_gnt && l_lock) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                l_gnt = l_req;
                if (!l_lock && !l_req) state_d = ST_RR;
            end
            default: state_d = ST_RR;
        endcase
        if (f_gnt)      last_d = REQ_F;
        else if (l_gnt) last_d = REQ_L;
    end

    imem_addr_check #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_addr_check (
        .addr_i  (chk_addr),
        .legal_o (chk_legal),
        .idx_o   (chk_idx)
    );

    // Memory request for the granted beat and next-cycle response routing
    always_comb begin
        chk_addr = l_gnt ? l_addr : f_addr;
        m_en     = (f_gnt || l_gnt) && chk_legal;
        m_we     = l_gnt && l_we && chk_legal;
        m_addr   = AW'({chk_idx, {WORD_SHIFT{1'b0}}});
        m_wdata  = l_wdata;
        rsp_d    = '0;
        rsp_d.f_vld = f_gnt;
        rsp_d.f_err = f_gnt && !chk_legal;
        rsp_d.f_rd  = f_gnt && chk_legal;
        rsp_d.l_vld = l_gnt;
        rsp_d.l_err = l_gnt && !chk_legal;
        rsp_d.l_rd  = l_gnt && chk_legal && !l_we;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_RR;
            last_q   <= REQ_L;
            rsp_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rsp_q    <= rsp_d;
            locked_q <= (state_d == ST_LOCKED);
        end
    end

    // Read data is only valid in the response cycle, so it is steered rather than stored
    always_comb begin
        f_rvalid = rsp_q.f_vld;
        f_err    = rsp_q.f_err;
        f_rdata  = rsp_q.f_rd ? m_rdata : '0;
        l_rvalid = rsp_q.l_vld;
        l_err    = rsp_q.l_err;
        l_rdata  = rsp_q.l_rd ? m_rdata : '0;
        locked   = locked_q;
    end

`ifdef IMEM_ARB_STATS_EN
    logic [STAT_W-1:0] sf_q, sl_q, sc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sf_q <= '0;
            sl_q <= '0;
            sc_q <= '0;
        end else begin
            if (f_gnt && (sf_q != '1)) sf_q <= sf_q + STAT_W'(1);
            if (l_gnt && (sl_q != '1)) sl_q <= sl_q + STAT_W'(1);
            if (f_req && l_req && (sc_q != '1)) sc_q <= sc_q + STAT_W'(1);
        end
    end

    assign stat_f_grants  = sf_q;
    assign stat_l_grants  = sl_q;
    assign stat_conflicts = sc_q;
`else
    assign stat_f_grants  = '0;
    assign stat_l_grants  = '0;
    assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a registered-read memory model.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, l_req, l_we, l_lock;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err, locked;
    logic [31:0] f_rdata, l_rdata;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata;
    logic [15:0] stat_f_grants, stat_l_grants, stat_conflicts;

    logic        preload;
    logic [31:0] mem [128];

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.DEPTH(128), .AW(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .f_req          (f_req),
        .f_addr         (f_addr),
        .f_gnt          (f_gnt),
        .f_rvalid       (f_rvalid),
        .f_rdata        (f_rdata),
        .f_err          (f_err),
        .l_req          (l_req),
        .l_we           (l_we),
        .l_lock         (l_lock),
        .l_addr         (l_addr),
        .l_wdata        (l_wdata),
        .l_gnt          (l_gnt),
        .l_rvalid       (l_rvalid),
        .l_rdata        (l_rdata),
        .l_err          (l_err),
        .locked         (locked),
        .m_en           (m_en),
        .m_we           (m_we),
        .m_addr         (m_addr),
        .m_wdata        (m_wdata),
        .m_rdata        (m_rdata),
        .stat_f_grants  (stat_f_grants),
        .stat_l_grants  (stat_l_grants),
        .stat_conflicts (stat_conflicts)
    );

    // Single-port memory, data out one cycle after a read enable; word i preloads to A000_0000+i
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            m_rdata <= '0;
        end else if (m_en && ((m_addr >> 2) < 32'd128)) begin
            if (m_we) mem[m_addr[8:2]] <= m_wdata;
            else      m_rdata <= mem[m_addr[8:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] bad_addr [4];
        logic        bad_legal [4];
        logic [31:0] bad_data [4];
        bad_addr[0] = 32'h0000_0002; bad_legal[0] = 1'b0; bad_data[0] = 32'h0;
        bad_addr[1] = 32'h0000_0200; bad_legal[1] = 1'b0; bad_data[1] = 32'h0;
        bad_addr[2] = 32'h0000_01FC; bad_legal[2] = 1'b1; bad_data[2] = 32'hA000_007F;
        bad_addr[3] = 32'h8000_0004; bad_legal[3] = 1'b0; bad_data[3] = 32'h0;

        reset = 1'b0; preload = 1'b1;
        f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
        f_addr = '0; l_addr = '0; l_wdata = '0;
        @(negedge clk); preload = 1'b0;
        @(posedge clk); #1;
        chk("rst_f_rvalid", f_rvalid, 0);
        chk("rst_l_rvalid", l_rvalid, 0);
        chk("rst_f_err", f_err, 0);
        chk("rst_locked", locked, 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_l_rdata", l_rdata, 0);
        chk("rst_stat_conf", 32'(stat_conflicts), 0);

        // Single fetch of word 1
        @(negedge clk); reset = 1'b1; f_req = 1'b1; f_addr = 32'h4; #1;
        chk("f1_gnt", f_gnt, 1);
        chk("f1_l_gnt", l_gnt, 0);
        chk("f1_m_en", m_en, 1);
        chk("f1_m_addr", m_addr, 32'h4);
        @(posedge clk); #1;
        chk("f1_rvalid", f_rvalid, 1);
        chk("f1_rdata", f_rdata, 32'hA000_0001);
        chk("f1_err", f_err, 0);
        chk("f1_l_rvalid", l_rvalid, 0);

        // Four-cycle conflict from reset alternates F,L,F,L
        do_reset();
        @(negedge clk);
        reset = 1'b1; f_req = 1'b1; l_req = 1'b1; f_addr = 32'h10; l_addr = 32'h14;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_f_gnt", f_gnt, (i % 2 == 0) ? 1 : 0);
            chk("rr_l_gnt", l_gnt, (i % 2 == 1) ? 1 : 0);
            @(posedge clk); #1;
            chk("rr_f_rvalid", f_rvalid, (i % 2 == 0) ? 1 : 0);
            chk("rr_l_rvalid", l_rvalid, (i % 2 == 1) ? 1 : 0);
            chk("rr_f_rdata", f_rdata, (i % 2 == 0) ? 32'hA000_0004 : 32'h0);
            chk("rr_l_rdata", l_rdata, (i % 2 == 1) ? 32'hA000_0005 : 32'h0);
            @(negedge clk);
        end

        // Locked write of DEADBEEF to word 2, fetch stalls
        f_req = 1'b0; l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1;
        l_addr = 32'h8; l_wdata = 32'hDEAD_BEEF; #1;
        chk("lk_l_gnt", l_gnt, 1);
        chk("lk_m_we", m_we, 1);
        chk("lk_m_en", m_en, 1);
        @(posedge clk); #1;
        chk("lk_locked", locked, 1);
        chk("lk_l_rvalid", l_rvalid, 1);
        chk("lk_l_rdata", l_rdata, 0);
        chk("lk_l_err", l_err, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'h8; #1;
            chk("lk_f_gnt", f_gnt, 0);
            chk("lk_locked_hold", locked, 1);
            @(posedge clk); #1;
            chk("lk_f_rvalid", f_rvalid, 0);
        end
        @(negedge clk); l_lock = 1'b0; #1;
        chk("unlk_f_gnt", f_gnt, 0);
        @(posedge clk); #1;
        chk("unlk_locked", locked, 0);
        @(negedge clk); #1;
        chk("rb_f_gnt", f_gnt, 1);
        @(posedge clk); #1;
        chk("rb_f_rvalid", f_rvalid, 1);
        chk("rb_f_rdata", f_rdata, 32'hDEAD_BEEF);

        // Address legality boundaries on the fetch port
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); f_req = 1'b1; f_addr = bad_addr[i]; #1;
            chk("ad_f_gnt", f_gnt, 1);
            chk("ad_m_en", m_en, 32'(bad_legal[i]));
            @(posedge clk); #1;
            chk("ad_f_rvalid", f_rvalid, 1);
            chk("ad_f_err", f_err, 32'(!bad_legal[i]));
            chk("ad_f_rdata", f_rdata, bad_data[i]);
        end

        // Misaligned loader write is suppressed and errors
        @(negedge clk); f_req = 1'b0; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h3; l_wdata = 32'h1234_5678; #1;
        chk("lw_l_gnt", l_gnt, 1);
        chk("lw_m_en", m_en, 0);
        chk("lw_m_we", m_we, 0);
        @(posedge clk); #1;
        chk("lw_l_rvalid", l_rvalid, 1);
        chk("lw_l_err", l_err, 1);
        chk("lw_l_rdata", l_rdata, 0);

        // Loader read-back of the locked write
        @(negedge clk); l_we = 1'b0; l_addr = 32'h8; #1;
        chk("lr_l_gnt", l_gnt, 1);
        @(posedge clk); #1;
        chk("lr_l_rdata", l_rdata, 32'hDEAD_BEEF);
        chk("lr_l_err", l_err, 0);

        // Reset lands on the edge that would register a granted locking read
        @(negedge clk); l_lock = 1'b1; l_addr = 32'hC; #1;
        chk("mr_l_gnt", l_gnt, 1);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("mr_l_rvalid", l_rvalid, 0);
        chk("mr_f_rvalid", f_rvalid, 0);
        chk("mr_locked", locked, 0);
        @(negedge clk);
        reset = 1'b1; l_lock = 1'b0; f_req = 1'b1; l_req = 1'b1; f_addr = 32'h0; l_addr = 32'h4; #1;
        chk("mr_first_f_gnt", f_gnt, 1);
        chk("mr_first_l_gnt", l_gnt, 0);
        @(posedge clk); #1;
        chk("mr_f_rdata", f_rdata, 32'hA000_0000);

        // Ten conflict cycles from reset
        do_reset();
        @(negedge clk);
        reset = 1'b1; f_req = 1'b1; l_req = 1'b1; f_addr = 32'h0; l_addr = 32'h4;
        repeat (10) @(posedge clk);
        @(negedge clk); f_req = 1'b0; l_req = 1'b0; #1;
`ifdef IMEM_ARB_STATS_EN
        chk("st_conflicts", 32'(stat_conflicts), 10);
        chk("st_f_grants", 32'(stat_f_grants), 5);
        chk("st_l_grants", 32'(stat_l_grants), 5);
`else
        chk("st_conflicts", 32'(stat_conflicts), 0);
        chk("st_f_grants", 32'(stat_f_grants), 0);
        chk("st_l_grants", 32'(stat_l_grants), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
